// File: rtl/cla_seq_pkg.sv
// Shared types and helpers for the nibble-serial CLA sequencer.
package cla_seq_pkg;

  localparam int NIBBLE_W  = 4;
  // Widest operand nibble_sel can slice from.
  localparam int SEL_MAX_W = 64;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} cla_seq_state_t;

  // Returns nibble idx of vec. Callers zero-extend their operand to SEL_MAX_W.
  function automatic logic [NIBBLE_W-1:0] nibble_sel(input logic [SEL_MAX_W-1:0] vec,
                                                     input int unsigned          idx);
    return vec[idx*NIBBLE_W +: NIBBLE_W];
  endfunction

endpackage

// File: rtl/cla_seq_ctrl.sv
// Nibble-serial adder sequencer. It adds two WIDTH-bit operands by driving one
// external pipelined 4-bit CLA stage once per nibble, starting with the least
// significant nibble. The carry from each pass is fed into the next pass.
// Optional: define CLA_SEQ_OVF_EN to add the two's-complement overflow output ovf.
module cla_seq_ctrl
  import cla_seq_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int ADD_LAT = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a_in,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b_in,
  input  logic                          c_in,
  output logic                          busy,
  output logic                          done,
  output logic [NIBBLE_W*NIBBLES-1:0]   s_out,
  output logic                          c_out,
`ifdef CLA_SEQ_OVF_EN
  output logic                          ovf,
`endif
  output logic [NIBBLE_W-1:0]           add_a,
  output logic [NIBBLE_W-1:0]           add_b,
  output logic                          add_cin,
  input  logic [NIBBLE_W-1:0]           add_s,
  input  logic                          add_cout
);

  localparam int WIDTH = NIBBLE_W*NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  cla_seq_state_t      r_state;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [IDX_W-1:0]    r_idx;
  logic                r_carry;
  logic [2:0]          r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [WIDTH-1:0]    r_s;
  logic                r_c;
  logic [NIBBLE_W-1:0] r_add_a;
  logic [NIBBLE_W-1:0] r_add_b;
  logic                r_add_cin;
`ifdef CLA_SEQ_OVF_EN
  logic                r_ovf;
`endif

  logic                w_last;
  logic [IDX_W-1:0]    w_next_idx;
  logic [NIBBLE_W-1:0] w_next_a;
  logic [NIBBLE_W-1:0] w_next_b;
  logic [NIBBLE_W-1:0] w_first_a;
  logic [NIBBLE_W-1:0] w_first_b;

  assign w_last     = (r_idx == IDX_W'(NIBBLES-1));
  assign w_next_idx = r_idx + 1'b1;
  assign w_next_a   = nibble_sel(SEL_MAX_W'(r_a), int'(w_next_idx));
  assign w_next_b   = nibble_sel(SEL_MAX_W'(r_b), int'(w_next_idx));
  assign w_first_a  = nibble_sel(SEL_MAX_W'(a_in), 0);
  assign w_first_b  = nibble_sel(SEL_MAX_W'(b_in), 0);

  // Sequencer FSM. The adder inputs are registered and loaded on the edge that
  // enters ISSUE. They stay stable through WAIT, as the external pipeline
  // requires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_s       <= '0;
      r_c       <= 1'b0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_cin <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      r_ovf     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_add_a   <= '0;
          r_add_b   <= '0;
          r_add_cin <= 1'b0;
          if (start) begin
            r_a       <= a_in;
            r_b       <= b_in;
            r_idx     <= '0;
            r_carry   <= c_in;
            r_add_a   <= w_first_a;
            r_add_b   <= w_first_b;
            r_add_cin <= c_in;
            r_busy    <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= 3'(ADD_LAT);
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          // A count of 1 here reaches 0 on this edge. This is the edge that samples the adder.
          if (r_cnt == 3'd1) begin
            r_s[r_idx*NIBBLE_W +: NIBBLE_W] <= add_s;
            r_carry <= add_cout;
            if (w_last) begin
              r_c       <= add_cout;
`ifdef CLA_SEQ_OVF_EN
              // On the top nibble, carry into the sign bit = s3 ^ a3 ^ b3.
              r_ovf     <= add_cout ^ (add_s[NIBBLE_W-1] ^ r_a[WIDTH-1] ^ r_b[WIDTH-1]);
`endif
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_add_a   <= '0;
              r_add_b   <= '0;
              r_add_cin <= 1'b0;
              r_state   <= DONE;
            end else begin
              r_idx     <= w_next_idx;
              r_add_a   <= w_next_a;
              r_add_b   <= w_next_b;
              r_add_cin <= add_cout;
              r_state   <= ISSUE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign s_out   = r_s;
  assign c_out   = r_c;
  assign add_a   = r_add_a;
  assign add_b   = r_add_b;
  assign add_cin = r_add_cin;
`ifdef CLA_SEQ_OVF_EN
  assign ovf     = r_ovf;
`endif

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Bench for cla_seq_ctrl. It models the external registered 4-bit CLA with ADD_LAT stages.
// Expected results go into a scoreboard queue when an op is started. They are
// popped and compared when done is seen.
`timescale 1ns/1ps
module tb_cla_seq_ctrl;

  localparam int NIB = 4;
  localparam int L   = 2;
  localparam int W   = 4*NIB;
  localparam int LAT = NIB*(L+1)+1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         c_in;
  logic         busy, done, c_out;
  logic [W-1:0] s_out;
  logic [3:0]   add_a, add_b, add_s;
  logic         add_cin, add_cout;
`ifdef CLA_SEQ_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;
  exp_t sb[$];

  logic obs_cin [NIB];

  always #5 clk = ~clk;

  cla_seq_ctrl #(.NIBBLES(NIB), .ADD_LAT(L)) dut (
    .clk(clk), .reset(reset), .start(start),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .busy(busy), .done(done), .s_out(s_out), .c_out(c_out),
`ifdef CLA_SEQ_OVF_EN
    .ovf(ovf),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  // External adder model: a 4-bit add followed by an L-deep register pipeline.
  logic [4:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + 5'(add_cin);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign {add_cout, add_s} = pipe[L-1];

  function automatic exp_t make_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t         e;
    logic [W:0]   t;
    t   = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    e.s = t[W-1:0];
    e.c = t[W];
    e.v = (a[W-1] == b[W-1]) && (e.s[W-1] != a[W-1]);
    return e;
  endfunction

  // Starts one op in the next cycle. Operands are scrambled after acceptance.
  // Adder inputs are checked in every ISSUE cycle. The result is compared at done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t        e;
    logic [W:0]  t, mask;
    logic        got;
    int          k;
    @(posedge clk); #1;
    start = 1'b1; a_in = a; b_in = b; c_in = cin;
    sb.push_back(make_exp(a, b, cin));
    got = 1'b0;
    for (int c = 1; c <= LAT + 10 && !got; c++) begin
      @(posedge clk); #1;
      start = 1'b0; a_in = W'($urandom); b_in = W'($urandom); c_in = 1'($urandom);
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_issue: got %b want 1", busy); end
      end
      if ((c-1) % (L+1) == 0 && (c-1)/(L+1) < NIB) begin
        k    = (c-1)/(L+1);
        mask = ((W+1)'(1) << (4*k)) - 1'b1;
        t    = ({1'b0, a} & mask) + ({1'b0, b} & mask) + (W+1)'(cin);
        obs_cin[k] = add_cin;
        checks++;
        if ({add_a, add_b, add_cin} !== {a[4*k +: 4], b[4*k +: 4], t[4*k]}) begin
          errors++;
          $display("FAIL issue_nibble%0d: got a=%h b=%h cin=%b want a=%h b=%h cin=%b",
                   k, add_a, add_b, add_cin, a[4*k +: 4], b[4*k +: 4], t[4*k]);
        end
      end
      if (done === 1'b1) begin
        got = 1'b1;
        checks++;
        if (c != LAT) begin errors++; $display("FAIL latency: got cycle %0d want %0d", c, LAT); end
        if (sb.size() == 0) begin
          checks++; errors++; $display("FAIL scoreboard_empty: got done want none");
        end else begin
          e = sb.pop_front();
          checks++;
          if ({c_out, s_out} !== {e.c, e.s}) begin
            errors++; $display("FAIL result: got c=%b s=%h want c=%b s=%h", c_out, s_out, e.c, e.s);
          end
`ifdef CLA_SEQ_OVF_EN
          checks++;
          if (ovf !== e.v) begin errors++; $display("FAIL ovf: got %b want %b", ovf, e.v); end
`endif
        end
      end
    end
    if (!got) begin checks++; errors++; $display("FAIL timeout: got no done want done at %0d", LAT); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy    !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done    !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (s_out   !== '0)   begin errors++; $display("FAIL rst_s: got %h want 0", s_out); end
    checks++; if (c_out   !== 1'b0) begin errors++; $display("FAIL rst_c: got %b want 0", c_out); end
    checks++; if ({add_a, add_b, add_cin} !== 9'd0) begin
      errors++; $display("FAIL rst_add: got %h/%h/%b want 0", add_a, add_b, add_cin);
    end
`ifdef CLA_SEQ_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_op(16'h1234, 16'h4321, 1'b0);
  endtask

  task automatic test_carry_chain();
    run_op(16'hFFFF, 16'h0001, 1'b0);
    for (int k = 1; k < NIB; k++) begin
      checks++;
      if (obs_cin[k] !== 1'b1) begin errors++; $display("FAIL chain_cin%0d: got %b want 1", k, obs_cin[k]); end
    end
  endtask

  task automatic test_cin_only();
    run_op(16'h0000, 16'h0000, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_op(16'h8000, 16'h8000, 1'b1);
    run_op(16'hA5A5, 16'h5A5B, 1'b0);
  endtask

  task automatic test_busy_reject();
    int   ndone;
    exp_t e;
    ndone = 0;
    @(posedge clk); #1;
    start = 1'b1; a_in = 16'h0F0F; b_in = 16'h0101; c_in = 1'b1;
    sb.push_back(make_exp(16'h0F0F, 16'h0101, 1'b1));
    for (int c = 1; c <= 2*LAT + 6; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 3 || c == 13) begin start = 1'b1; a_in = 16'hAAAA; b_in = 16'h7777; c_in = 1'b1; end
      if (c == 14) begin
        start = 1'b1; a_in = 16'h3C3C; b_in = 16'hC3C4; c_in = 1'b0;
        sb.push_back(make_exp(16'h3C3C, 16'hC3C4, 1'b0));
      end
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (c != (ndone == 1 ? LAT : 14 + LAT)) begin
          errors++; $display("FAIL reject_done_cycle: got %0d want %0d", c, (ndone == 1 ? LAT : 14 + LAT));
        end
        if (sb.size() == 0) begin
          checks++; errors++; $display("FAIL reject_extra_done: got done at %0d want none", c);
        end else begin
          e = sb.pop_front();
          checks++;
          if ({c_out, s_out} !== {e.c, e.s}) begin
            errors++; $display("FAIL reject_result: got c=%b s=%h want c=%b s=%h", c_out, s_out, e.c, e.s);
          end
        end
      end
    end
    checks++;
    if (ndone != 2) begin errors++; $display("FAIL reject_done_count: got %0d want 2", ndone); end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; a_in = 16'hFFFF; b_in = 16'hFFFF; c_in = 1'b1;
    sb.push_back(make_exp(16'hFFFF, 16'hFFFF, 1'b1));
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 6) begin
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, c_out, s_out} !== '0) begin
          errors++; $display("FAIL abort_clear: got busy=%b done=%b c=%b s=%h want all 0", busy, done, c_out, s_out);
        end
      end else begin
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL abort_early_done: got 1 want 0 in cycle %0d", c); end
      end
    end
    e = sb.pop_front();
    @(negedge clk);
    reset = 1'b0;
    run_op(16'h00FF, 16'h0001, 1'b0);
  endtask

`ifdef CLA_SEQ_OVF_EN
  task automatic test_ovf();
    run_op(16'h7FFF, 16'h0001, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_cin_only();
    test_back_to_back();
    test_busy_reject();
    test_reset_abort();
`ifdef CLA_SEQ_OVF_EN
    test_ovf();
`endif
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
